// File: rtl/fpu_divsqrt_iter.sv
// Radix-2 iterative floating-point divide / square root with IEEE rounding and flags.
// Square root is present only when FPU_DIVSQRT_SQRT_EN is defined; otherwise op_i=1 returns qNaN with NV.
module fpu_divsqrt_iter #(
  parameter int  EXP_W  = 8,
  parameter int  MANT_W = 23,
  localparam int OP_W   = 1 + EXP_W + MANT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            op_i,
  input  logic [OP_W-1:0] operand_a_i,
  input  logic [OP_W-1:0] operand_b_i,
  input  logic [2:0]      rm_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [OP_W-1:0] result_o,
  output logic [4:0]      fflags_o
);
  localparam int N     = MANT_W + 3;
  localparam int SE_W  = EXP_W + 2;
  localparam int R_W   = N + 2;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic signed [SE_W-1:0] BIAS    = SE_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [SE_W-1:0] EXP_MAX = SE_W'((1 << EXP_W) - 1);
  localparam logic signed [SE_W-1:0] ONE     = SE_W'(1);
  localparam logic [OP_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [4:0] F_NV = 5'b10000, F_DZ = 5'b01000, F_OF_NX = 5'b00101, F_UF_NX = 5'b00011;

  typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_e;

  function automatic logic round_inc(input logic [2:0] rm, input logic sign, input logic lsb,
                                     input logic g, input logic s);
    case (rm)
      3'd1:    round_inc = 1'b0;
      3'd2:    round_inc = sign & (g | s);
      3'd3:    round_inc = ~sign & (g | s);
      3'd4:    round_inc = g;
      default: round_inc = g & (s | lsb);
    endcase
  endfunction

  function automatic logic [OP_W-1:0] ovf_result(input logic [2:0] rm, input logic sign);
    logic to_inf;
    case (rm)
      3'd1:    to_inf = 1'b0;
      3'd2:    to_inf = sign;
      3'd3:    to_inf = ~sign;
      default: to_inf = 1'b1;
    endcase
    ovf_result = to_inf ? {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}}
                        : {sign, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
  endfunction

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OP_W-1:0]         res_q, res_d;
  logic [4:0]              flags_q, flags_d;
  logic                    sign_q, sign_d;
  logic signed [SE_W-1:0]  exp_q, exp_d;
  logic [2:0]              rm_q, rm_d;
  logic [R_W-1:0]          rem_q, rem_d;
  logic [N-1:0]            quo_q, quo_d;
  logic [MANT_W:0]         div_q, div_d;
`ifdef FPU_DIVSQRT_SQRT_EN
  logic                    op_q, op_d;
  logic [2*N-1:0]          rad_q, rad_d;
  logic signed [SE_W-1:0]  unb;
  logic [R_W-1:0]          rem2, trial;
`endif

  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] fa, fb;
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b, sq;
  logic special, accept;
  logic [OP_W-1:0] spec_res;
  logic [4:0]      spec_flags;

  assign {sa, ea, fa} = operand_a_i;
  assign {sb, eb, fb} = operand_b_i;
  // Denormals have a zero exponent and are treated as signed zeros
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign inf_a  = (ea == '1) && (fa == '0);
  assign inf_b  = (eb == '1) && (fb == '0);
  assign nan_a  = (ea == '1) && (fa != '0);
  assign nan_b  = (eb == '1) && (fb != '0);
  assign snan_a = nan_a && !fa[MANT_W-1];
  assign snan_b = nan_b && !fb[MANT_W-1];
  assign sq     = sa ^ sb;
  assign accept = (state_q == IDLE) && valid_i && !kill_i;

  always_comb begin
    special    = 1'b1;
    spec_res   = QNAN;
    spec_flags = '0;
    if (op_i) begin
`ifdef FPU_DIVSQRT_SQRT_EN
      if (nan_a)       spec_flags = {snan_a, 4'b0};
      else if (zero_a) spec_res   = {sa, {(OP_W-1){1'b0}}};
      else if (sa)     spec_flags = F_NV;
      else if (inf_a)  spec_res   = {1'b0, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      else             special    = 1'b0;
`else
      spec_flags = F_NV;
`endif
    end else if (nan_a || nan_b) begin
      spec_flags = {snan_a | snan_b, 4'b0};
    end else if ((zero_a && zero_b) || (inf_a && inf_b)) begin
      spec_flags = F_NV;
    end else if (inf_a) begin
      spec_res = {sq, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (zero_b) begin
      spec_res   = {sq, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      spec_flags = F_DZ;
    end else if (zero_a || inf_b) begin
      spec_res = {sq, {(OP_W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // Rounding: quotient/root integer bit decides the 1-bit normalisation
  logic                   norm, g_bit, s_bit, inc, carry;
  logic [MANT_W:0]        mant;
  logic [MANT_W+1:0]      mant_r;
  logic [MANT_W-1:0]      frac;
  logic signed [SE_W-1:0] e_n, e_r;

  always_comb begin
    norm   = quo_q[N-1];
    mant   = norm ? quo_q[N-1:2] : quo_q[N-2:1];
    g_bit  = norm ? quo_q[1] : quo_q[0];
    s_bit  = (norm & quo_q[0]) | (rem_q != '0);
    e_n    = norm ? exp_q : exp_q - ONE;
    inc    = round_inc(rm_q, sign_q, mant[0], g_bit, s_bit);
    mant_r = {1'b0, mant} + {{(MANT_W+1){1'b0}}, inc};
    carry  = mant_r[MANT_W+1];
    frac   = carry ? mant_r[MANT_W:1] : mant_r[MANT_W-1:0];
    e_r    = carry ? e_n + ONE : e_n;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    rm_d    = rm_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
`ifdef FPU_DIVSQRT_SQRT_EN
    op_d    = op_q;
    rad_d   = rad_q;
    unb     = $signed({2'b00, ea}) - BIAS;
    rem2    = {rem_q[R_W-3:0], rad_q[2*N-1:2*N-2]};
    trial   = {quo_q, 2'b01};
`endif
    case (state_q)
      IDLE: if (accept) begin
        rm_d   = rm_i;
        sign_d = sq;
        rem_d  = R_W'({1'b1, fa});
        quo_d  = '0;
        div_d  = {1'b1, fb};
        exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
`ifdef FPU_DIVSQRT_SQRT_EN
        op_d = op_i;
        if (op_i) begin
          // Odd unbiased exponent: fold the spare factor of 2 into the radicand
          sign_d = 1'b0;
          rem_d  = '0;
          exp_d  = (unb >>> 1) + BIAS;
          rad_d  = {(unb[0] ? {1'b1, fa, 1'b0} : {2'b01, fa}), {(MANT_W+4){1'b0}}};
        end
`endif
        if (special) begin
          state_d = DONE;
          res_d   = spec_res;
          flags_d = spec_flags;
        end else begin
          state_d = ITER;
          cnt_d   = CNT_W'(N);
        end
      end
      ITER: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ROUND;
`ifdef FPU_DIVSQRT_SQRT_EN
        if (op_q) begin
          quo_d = {quo_q[N-2:0], rem2 >= trial};
          rem_d = (rem2 >= trial) ? rem2 - trial : rem2;
          rad_d = rad_q << 2;
        end else
`endif
        begin
          quo_d = {quo_q[N-2:0], rem_q >= R_W'(div_q)};
          rem_d = ((rem_q >= R_W'(div_q)) ? rem_q - R_W'(div_q) : rem_q) << 1;
        end
      end
      ROUND: begin
        state_d = DONE;
        if (e_r >= EXP_MAX) begin
          res_d   = ovf_result(rm_q, sign_q);
          flags_d = F_OF_NX;
        end else if (e_r[SE_W-1] || e_r == '0) begin
          res_d   = {sign_q, {(OP_W-1){1'b0}}};
          flags_d = F_UF_NX;
        end else begin
          res_d   = {sign_q, e_r[EXP_W-1:0], frac};
          flags_d = {4'b0, g_bit | s_bit};
        end
      end
      DONE: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    exp_q  <= exp_d;
    rm_q   <= rm_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    div_q  <= div_d;
`ifdef FPU_DIVSQRT_SQRT_EN
    op_q   <= op_d;
    rad_q  <= rad_d;
`endif
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = res_q;
  assign fflags_o = flags_q;

endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
// Directed bench for fpu_divsqrt_iter: single-precision instance plus a half-precision instance.
module tb_fpu_divsqrt_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, op_i = 1'b0, kill_i = 1'b0, ready_i = 1'b1;
  logic [31:0] a_i = '0, b_i = '0;
  logic [2:0]  rm_i = '0;
  logic        ready_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  logic        h_valid_i = 1'b0, h_op_i = 1'b0, h_kill_i = 1'b0, h_ready_i = 1'b1;
  logic [15:0] h_a_i = '0, h_b_i = '0;
  logic [2:0]  h_rm_i = '0;
  logic        h_ready_o, h_valid_o;
  logic [15:0] h_result_o;
  logic [4:0]  h_fflags_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpu_divsqrt_iter dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .operand_a_i(a_i), .operand_b_i(b_i), .rm_i(rm_i), .kill_i(kill_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .fflags_o(fflags_o)
  );

  fpu_divsqrt_iter #(.EXP_W(5), .MANT_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .valid_i(h_valid_i), .ready_o(h_ready_o), .op_i(h_op_i),
    .operand_a_i(h_a_i), .operand_b_i(h_b_i), .rm_i(h_rm_i), .kill_i(h_kill_i),
    .valid_o(h_valid_o), .ready_i(h_ready_i), .result_o(h_result_o), .fflags_o(h_fflags_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Latency counts edges with the accept edge as edge 1
  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, output logic [31:0] res, output logic [4:0] fl,
                       output int lat);
    int guard = 0;
    @(negedge clk);
    while (!ready_o && guard < 200) begin @(negedge clk); guard++; end
    op_i = op; a_i = a; b_i = b; rm_i = rm; valid_i = 1'b1;
    @(posedge clk); #1; valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!valid_o) lat = -1;
    res = result_o; fl = fflags_o;
  endtask

  task automatic do_op_h(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic [4:0] fl, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!h_ready_o && guard < 200) begin @(negedge clk); guard++; end
    h_op_i = 1'b0; h_a_i = a; h_b_i = b; h_rm_i = 3'd0; h_valid_i = 1'b1;
    @(posedge clk); #1; h_valid_i = 1'b0;
    lat = 1;
    while (!h_valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!h_valid_o) lat = -1;
    res = h_result_o; fl = h_fflags_o;
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] rh;
    logic [4:0]  f;
    int          lat;
    logic        seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_flags", fflags_o, 0);
    @(negedge clk); rst_n = 1'b1;

    do_op(0, 32'h40C00000, 32'h40400000, 3'd0, r, f, lat);
    chk("div6_3_res", r, 32'h40000000); chk("div6_3_fl", f, 0); chk("div6_3_lat", lat, 28);

    do_op(0, 32'h3F800000, 32'h40400000, 3'd0, r, f, lat);
    chk("div1_3_rne_res", r, 32'h3EAAAAAB); chk("div1_3_rne_fl", f, 5'h01);
    do_op(0, 32'h3F800000, 32'h40400000, 3'd1, r, f, lat);
    chk("div1_3_rtz_res", r, 32'h3EAAAAAA); chk("div1_3_rtz_fl", f, 5'h01);
    do_op(0, 32'hBF800000, 32'h40400000, 3'd2, r, f, lat);
    chk("divm1_3_rdn_res", r, 32'hBEAAAAAB);
    do_op(0, 32'hBF800000, 32'h40400000, 3'd3, r, f, lat);
    chk("divm1_3_rup_res", r, 32'hBEAAAAAA);

`ifdef FPU_DIVSQRT_SQRT_EN
    do_op(1, 32'h40800000, 32'h0, 3'd0, r, f, lat);
    chk("sqrt4_res", r, 32'h40000000); chk("sqrt4_fl", f, 0); chk("sqrt4_lat", lat, 28);
    do_op(1, 32'h40000000, 32'h0, 3'd0, r, f, lat);
    chk("sqrt2_res", r, 32'h3FB504F3); chk("sqrt2_fl", f, 5'h01);
`else
    do_op(1, 32'h40800000, 32'h0, 3'd0, r, f, lat);
    chk("sqrt_off_res", r, 32'h7FC00000); chk("sqrt_off_fl", f, 5'h10);
    chk("sqrt_off_lat", lat, 1);
`endif
    do_op(1, 32'hBF800000, 32'h0, 3'd0, r, f, lat);
    chk("sqrt_neg_res", r, 32'h7FC00000); chk("sqrt_neg_fl", f, 5'h10);
    chk("sqrt_neg_lat", lat, 1);

    do_op(0, 32'h3F800000, 32'h00000000, 3'd0, r, f, lat);
    chk("div_by0_res", r, 32'h7F800000); chk("div_by0_fl", f, 5'h08);
    chk("div_by0_lat", lat, 1);
    do_op(0, 32'h00000000, 32'h00000000, 3'd0, r, f, lat);
    chk("zero_zero_res", r, 32'h7FC00000); chk("zero_zero_fl", f, 5'h10);
    chk("zero_zero_lat", lat, 1);

    do_op(0, 32'h7F7FFFFF, 32'h3F000000, 3'd0, r, f, lat);
    chk("ovf_rne_res", r, 32'h7F800000); chk("ovf_rne_fl", f, 5'h05);
    do_op(0, 32'h7F7FFFFF, 32'h3F000000, 3'd1, r, f, lat);
    chk("ovf_rtz_res", r, 32'h7F7FFFFF); chk("ovf_rtz_fl", f, 5'h05);
    do_op(0, 32'h00800000, 32'h40000000, 3'd0, r, f, lat);
    chk("unf_res", r, 32'h00000000); chk("unf_fl", f, 5'h03);

    // Abort in the 10th ITER cycle
    @(negedge clk);
    op_i = 1'b0; a_i = 32'h40C00000; b_i = 32'h40400000; rm_i = 3'd0; valid_i = 1'b1;
    @(posedge clk); #1; valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1; kill_i = 1'b1;
    @(posedge clk); #1; kill_i = 1'b0;
    chk("kill_ready", ready_o, 1);
    chk("kill_valid", valid_o, 0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (valid_o) seen = 1'b1; end
    chk("kill_no_result", seen, 0);

    // Consumer stall in DONE
    ready_i = 1'b0;
    do_op(0, 32'h40C00000, 32'h40400000, 3'd0, r, f, lat);
    chk("stall_lat", lat, 28);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", valid_o, 1);
      chk("stall_res", result_o, 32'h40000000);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("retire_valid", valid_o, 0);
    chk("retire_ready", ready_o, 1);
    @(posedge clk); #1;
    chk("retire_once", valid_o, 0);

    do_op_h(16'h4600, 16'h4200, rh, f, lat);
    chk("half_res", rh, 16'h4000); chk("half_fl", f, 0); chk("half_lat", lat, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
